// File: rtl/pipeline_stage_skid.sv
// Elastic pipeline stage: main + skid entry with valid/ready handshake,
// full flush and age-based selective squash on active-list tags.
module pipeline_stage_skid #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned PAYLOAD_WIDTH   = 128,
  parameter int unsigned FREE_LIST_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       squash_valid,
  input  logic [FREE_LIST_WIDTH-1:0] squash_index,
  input  logic [FREE_LIST_WIDTH-1:0] squash_head,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH-1:0]      in_pc,
  input  logic [PAYLOAD_WIDTH-1:0]   in_payload,
  input  logic [FREE_LIST_WIDTH-1:0] in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_WIDTH-1:0]      out_pc,
  output logic [PAYLOAD_WIDTH-1:0]   out_payload,
  output logic [FREE_LIST_WIDTH-1:0] out_tag,
  output logic [1:0]                 occupancy
);

  typedef struct packed {
    logic                       valid;
    logic [FREE_LIST_WIDTH-1:0] tag;
    logic [ADDR_WIDTH-1:0]      pc;
    logic [PAYLOAD_WIDTH-1:0]   payload;
  } entry_t;

  entry_t main_q, skid_q, main_d, skid_d, in_e;
  logic   in_ready_q;
  logic [1:0] occ_q;

  logic [FREE_LIST_WIDTH-1:0] age_ref, age_main, age_skid, age_in;
  logic main_keep, skid_keep, in_keep;

  always_comb begin
    in_e.valid   = 1'b1;
    in_e.tag     = in_tag;
    in_e.pc      = in_pc;
    in_e.payload = in_payload;

    // Ages relative to the active-list head; modulo wrap comes from truncation.
    age_ref  = squash_index - squash_head;
    age_main = main_q.tag - squash_head;
    age_skid = skid_q.tag - squash_head;
    age_in   = in_tag - squash_head;

    main_keep = main_q.valid && !(main_q.valid && out_ready)
                && !(squash_valid && (age_main > age_ref));
    skid_keep = skid_q.valid && !(squash_valid && (age_skid > age_ref));
    in_keep   = in_valid && in_ready_q && !(squash_valid && (age_in > age_ref));

    main_d = '0;
    skid_d = '0;
    // Survivors are packed oldest-first: main, then skid, then input.
    // Skid valid implies in_ready low, so at most two survivors exist.
    if (!flush) begin
      if (main_keep) begin
        main_d = main_q;
        if (skid_keep)
          skid_d = skid_q;
        else if (in_keep)
          skid_d = in_e;
      end else if (skid_keep) begin
        main_d = skid_q;
      end else if (in_keep) begin
        main_d = in_e;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      occ_q      <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= !skid_d.valid;
      occ_q      <= {1'b0, main_d.valid} + {1'b0, skid_d.valid};
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_q.valid;
  assign out_pc      = main_q.pc;
  assign out_payload = main_q.payload;
  assign out_tag     = main_q.tag;
  assign occupancy   = occ_q;

endmodule
